// File: rtl/usfft_pkg.sv
// Shared types and helpers for the unary SFFT stream decoder.
// Holds the FSM state encoding, default window sizing and the bipolar decode function.
// Optional feature macro: USFFT_SCALE_COMP_EN (scale compensation shift inside bipolar_decode).
package usfft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int BITWIDTH_DFLT    = 8;
  localparam int SCALE_SHIFT_DFLT = 2;
  localparam int N                = 1 << BITWIDTH_DFLT;

`ifdef USFFT_SCALE_COMP_EN
  localparam bit SCALE_COMP_EN = 1'b1;
`else
  localparam bit SCALE_COMP_EN = 1'b0;
`endif

  // Bipolar map of a ones count over a window of 2^bitwidth samples:
  // v = 2*count - N, optionally scaled back up by 2^shift, then clamped to
  // the representable signed range [-N, N-1] (count == N would give +N).
  function automatic int bipolar_decode(input int count, input int bitwidth, input int shift);
    int n;
    int v;
    n = 1 << bitwidth;
    v = 2 * count - n;
    if (SCALE_COMP_EN) begin
      v = v <<< shift;
    end
    if (v > n - 1) begin
      v = n - 1;
    end else if (v < -n) begin
      v = -n;
    end
    return v;
  endfunction

endpackage

// File: rtl/ustream_ctr.sv
// Ones counter for one bipolar bitstream channel.
// Latency: count register updates on the enabled edge; 'ones' already includes the current enabled bit.
// Backpressure: none; the owner pauses it by dropping 'en'.
// Ports: clk, rst (async, active high), clr (sync clear, wins over en), en (sample qualifier),
//        stream (bitstream input), ones (count including the bit being sampled this cycle).
module ustream_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         stream,
  output logic [W-1:0] ones
);

  logic [W-1:0] count_q;

  // Look-ahead value lets the owner register a decode on the same edge that
  // samples the final bit of the window.
  assign ones = count_q + W'(en & stream);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= ones;
    end
  end

endmodule

// File: rtl/usfft_stream_decoder.sv
// Converts four bipolar bitstreams (real0/img0/real1/img1) into signed words over a 2^BITWIDTH-sample window.
// Latency: result registered on the edge sampling the N-th enabled bit; oValid high from the next cycle.
// Backpressure: result held with oValid until iReady; iReady&iStart restarts with no bubble.
// Ports: iClk, iRst (async active high), iEn, iStart, iClr, iReal0/iImg0/iReal1/iImg1 (streams),
//        iReady, oBusy (RUN), oValid (HOLD), oReal0/oImg0/oReal1/oImg1 (signed BITWIDTH+1).
// Optional feature macro: USFFT_SCALE_COMP_EN (left shift by SCALE_SHIFT with saturation).
module usfft_stream_decoder
  import usfft_pkg::*;
#(
  parameter int BITWIDTH    = BITWIDTH_DFLT,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DFLT
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iEn,
  input  logic                       iStart,
  input  logic                       iClr,
  input  logic                       iReal0,
  input  logic                       iImg0,
  input  logic                       iReal1,
  input  logic                       iImg1,
  input  logic                       iReady,
  output logic                       oBusy,
  output logic                       oValid,
  output logic signed [BITWIDTH:0]   oReal0,
  output logic signed [BITWIDTH:0]   oImg0,
  output logic signed [BITWIDTH:0]   oReal1,
  output logic signed [BITWIDTH:0]   oImg1
);

  localparam int W   = BITWIDTH + 1;
  localparam int NCH = 4;

  state_t                   state;
  state_t                   state_nxt;
  logic                     start_acc;
  logic                     run_en;
  logic                     last_smp;
  logic                     load;
  logic                     ctr_clr;
  logic [BITWIDTH-1:0]      smp_cnt;
  logic [NCH-1:0]           streams;
  logic [BITWIDTH:0]        ones [NCH];
  logic signed [BITWIDTH:0] dec  [NCH];

  assign streams  = {iImg1, iReal1, iImg0, iReal0};
  assign run_en   = (state == ST_RUN) && iEn;
  assign last_smp = run_en && (smp_cnt == {BITWIDTH{1'b1}});
  // An abort on the final sample leaves the previous result in place.
  assign load     = last_smp && !iClr;
  assign ctr_clr  = iClr || start_acc;
  assign oBusy    = (state == ST_RUN);
  assign oValid   = (state == ST_HOLD);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    if (iClr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state_nxt = ST_RUN;
            start_acc = 1'b1;
          end
        end
        ST_RUN: begin
          if (last_smp) begin
            state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (iReady) begin
            if (iStart) begin
              state_nxt = ST_RUN;
              start_acc = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wraps to zero on the N-th sample, so it is already clear if the window
  // restarts back-to-back.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      smp_cnt <= '0;
    end else if (ctr_clr) begin
      smp_cnt <= '0;
    end else if (run_en) begin
      smp_cnt <= smp_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ctr
    ustream_ctr #(
      .W(W)
    ) u_ctr (
      .clk    (iClk),
      .rst    (iRst),
      .clr    (ctr_clr),
      .en     (run_en),
      .stream (streams[g]),
      .ones   (ones[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      dec[i] = W'(bipolar_decode(int'(ones[i]), BITWIDTH, SCALE_SHIFT));
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oReal0 <= '0;
      oImg0  <= '0;
      oReal1 <= '0;
      oImg1  <= '0;
    end else if (load) begin
      oReal0 <= dec[0];
      oImg0  <= dec[1];
      oReal1 <= dec[2];
      oImg1  <= dec[3];
    end
  end

endmodule
